riscv_core_rv32i: RTL and testbench

- Single-cycle RV32I integer core with instruction and data memories built in; it is the top of the CPU sub-system.
- The program is preloaded by hierarchical write into the instruction memory array. Execution starts when reset is released.
- No external bus. Architectural state is observed hierarchically.

---
 rtl/riscv_pkg.sv | 79 +++++++
 rtl/riscv_mem.sv | 26 ++
 rtl/riscv_core_rv32i.sv | 176 +++++++++++++++++
 tb/tb_riscv_core_rv32i.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, funct3 codes, ALU operations,
// immediate formats and the immediate/ALU-select helper functions.
package riscv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Register / immediate arithmetic funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Load / store width funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_e;

    function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_type_e kind);
        logic [31:0] imm;
        case (kind)
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = {{20{instr[31]}}, instr[31:20]};
        endcase
        return imm;
    endfunction

    // alt selects SUB over ADD, or SRA over SRL
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/riscv_mem.sv
// Word-wide memory: combinational read, byte-enabled write on the rising edge.
module riscv_mem #(
    parameter int DEPTH = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [DEPTH-1:0] addr,
    input  logic [3:0]       be,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [0:2**DEPTH-1];

    assign rdata = mem[addr];

    // Write only the enabled byte lanes of the addressed word
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/riscv_core_rv32i.sv
// Single-cycle RV32I core with built-in instruction and data memories.
// Optional macro RISCV_CORE_TRACE_EN prints one trace line per retired instruction.
module riscv_core_rv32i #(
    parameter int          DEPTH    = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic clk,
    input logic rst_n
);
    import riscv_pkg::*;

    logic [31:0] pc;
    logic [31:0] regs [0:31];
    logic [31:0] instr, imm, next_pc, pc_plus4;
    logic [31:0] rs1_val, rs2_val, alu_a, alu_b, alu_result, rd_wdata;
    logic [31:0] dmem_rdata, dmem_wdata, load_data;
    logic [3:0]  dmem_be;
    logic        dmem_we;
    logic [6:0]  opcode;
    logic [4:0]  rd_idx, rs1_idx, rs2_idx;
    logic [2:0]  funct3;
    imm_type_e   imm_type;
    alu_op_e     alu_op;
    logic        src_a_pc, src_b_imm, rd_we, is_load, is_store, is_branch, is_jal, is_jalr;
    logic        br_taken;

    riscv_mem #(.DEPTH(DEPTH)) instr_mem (
        .clk(clk), .we(1'b0), .addr(pc[DEPTH+1:2]), .be(4'b0000),
        .wdata(32'h0), .rdata(instr)
    );

    riscv_mem #(.DEPTH(DEPTH)) data_mem (
        .clk(clk), .we(dmem_we), .addr(alu_result[DEPTH+1:2]), .be(dmem_be),
        .wdata(dmem_wdata), .rdata(dmem_rdata)
    );

    assign opcode   = instr[6:0];
    assign rd_idx   = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1_idx  = instr[19:15];
    assign rs2_idx  = instr[24:20];
    assign imm      = gen_imm(instr, imm_type);
    assign rs1_val  = (rs1_idx == 5'd0) ? 32'h0 : regs[rs1_idx];
    assign rs2_val  = (rs2_idx == 5'd0) ? 32'h0 : regs[rs2_idx];
    assign alu_a    = src_a_pc ? pc : rs1_val;
    assign alu_b    = src_b_imm ? imm : rs2_val;
    assign pc_plus4 = pc + 32'd4;

    // Decode: unrecognised opcodes (incl. FENCE/SYSTEM) fall through as NOP
    always_comb begin
        imm_type  = IMM_I;
        alu_op    = ALU_ADD;
        src_a_pc  = 1'b0;
        src_b_imm = 1'b1;
        rd_we     = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        case (opcode)
            OP_LUI:    begin imm_type = IMM_U; alu_op = ALU_PASS_B; rd_we = 1'b1; end
            OP_AUIPC:  begin imm_type = IMM_U; src_a_pc = 1'b1; rd_we = 1'b1; end
            OP_JAL:    begin imm_type = IMM_J; is_jal = 1'b1; rd_we = 1'b1; end
            OP_JALR:   begin is_jalr = 1'b1; rd_we = 1'b1; end
            OP_BRANCH: begin imm_type = IMM_B; is_branch = 1'b1; end
            OP_LOAD:   begin is_load = 1'b1; rd_we = 1'b1; end
            OP_STORE:  begin imm_type = IMM_S; is_store = 1'b1; end
            OP_IMM:    begin
                alu_op = alu_from_f3(funct3, (funct3 == F3_SR) && instr[30]);
                rd_we  = 1'b1;
            end
            OP_REG:    begin
                alu_op    = alu_from_f3(funct3, instr[30]);
                src_b_imm = 1'b0;
                rd_we     = 1'b1;
            end
            default:   ;
        endcase
    end

    // ALU: 32-bit wrap-around arithmetic, shifts by the low five bits of b
    always_comb begin
        alu_result = 32'h0;
        case (alu_op)
            ALU_ADD:    alu_result = alu_a + alu_b;
            ALU_SUB:    alu_result = alu_a - alu_b;
            ALU_SLL:    alu_result = alu_a << alu_b[4:0];
            ALU_SLT:    alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU:   alu_result = {31'b0, alu_a < alu_b};
            ALU_XOR:    alu_result = alu_a ^ alu_b;
            ALU_SRL:    alu_result = alu_a >> alu_b[4:0];
            ALU_SRA:    alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            ALU_OR:     alu_result = alu_a | alu_b;
            ALU_AND:    alu_result = alu_a & alu_b;
            ALU_PASS_B: alu_result = alu_b;
            default:    alu_result = 32'h0;
        endcase
    end

    // Branch condition on the two register operands
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            F3_BEQ:  br_taken = (rs1_val == rs2_val);
            F3_BNE:  br_taken = (rs1_val != rs2_val);
            F3_BLT:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
            F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: br_taken = (rs1_val < rs2_val);
            F3_BGEU: br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    // Load lane extraction; misaligned halfwords use addr[1] only
    always_comb begin
        load_data = dmem_rdata;
        case (funct3)
            F3_B:    load_data = {{24{dmem_rdata[8*alu_result[1:0] + 7]}}, dmem_rdata[8*alu_result[1:0] +: 8]};
            F3_BU:   load_data = {24'b0, dmem_rdata[8*alu_result[1:0] +: 8]};
            F3_H:    load_data = {{16{dmem_rdata[16*alu_result[1] + 15]}}, dmem_rdata[16*alu_result[1] +: 16]};
            F3_HU:   load_data = {16'b0, dmem_rdata[16*alu_result[1] +: 16]};
            default: load_data = dmem_rdata;
        endcase
    end

    // Store lane replication and byte enables; reset blocks every write
    always_comb begin
        dmem_be    = 4'b0000;
        dmem_wdata = rs2_val;
        case (funct3)
            F3_B:    begin dmem_be = 4'b0001 << alu_result[1:0]; dmem_wdata = {4{rs2_val[7:0]}}; end
            F3_H:    begin dmem_be = alu_result[1] ? 4'b1100 : 4'b0011; dmem_wdata = {2{rs2_val[15:0]}}; end
            F3_W:    dmem_be = 4'b1111;
            default: dmem_be = 4'b0000;
        endcase
        dmem_we = is_store && rst_n;
    end

    // Writeback value and next pc selection
    always_comb begin
        rd_wdata = alu_result;
        if (is_load)                rd_wdata = load_data;
        else if (is_jal || is_jalr) rd_wdata = pc_plus4;
        next_pc = pc_plus4;
        if (is_jalr)                                next_pc = alu_result & ~32'd1;
        else if (is_jal || (is_branch && br_taken)) next_pc = pc + imm;
    end

    // Architectural state: pc and register file retire together each edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else begin
            pc <= next_pc;
            if (rd_we && (rd_idx != 5'd0)) regs[rd_idx] <= rd_wdata;
        end
    end

`ifdef RISCV_CORE_TRACE_EN
    // Simulation trace of each retired instruction
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (rd_we && (rd_idx != 5'd0))
                $display("trace pc=%08h instr=%08h rd=x%0d wdata=%08h", pc, instr, rd_idx, rd_wdata);
            else if (dmem_we)
                $display("trace pc=%08h instr=%08h store addr=%08h data=%08h be=%b",
                         pc, instr, alu_result, dmem_wdata, dmem_be);
            else
                $display("trace pc=%08h instr=%08h", pc, instr);
        end
    end
`endif

endmodule

// File: tb/tb_riscv_core_rv32i.sv
// Directed-program bench: stimulus pushes expected architectural values,
// a negedge monitor pops and compares them against the core's state.
module tb_riscv_core_rv32i;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int SEL_PC  = 32;
    localparam int SEL_MEM = 64;

    logic clk;
    logic rst_n;

    logic [31:0] exp_q[$];
    int          sel_q[$];
    int          checks = 0;
    int          errors = 0;

    int          mon_sel;
    logic [31:0] mon_exp;
    logic [31:0] mon_act;

    riscv_core_rv32i #(.DEPTH(10), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk),
        .rst_n(rst_n)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] probe(input int sel);
        if (sel < 32)        return dut.regs[sel];
        else if (sel == SEL_PC) return dut.pc;
        else                 return dut.data_mem.mem[sel - SEL_MEM];
    endfunction

    function automatic string probe_name(input int sel);
        if (sel < 32)        return $sformatf("x%0d", sel);
        else if (sel == SEL_PC) return "pc";
        else                 return $sformatf("dmem[%0d]", sel - SEL_MEM);
    endfunction

    // Scoreboard monitor: compare every pending expectation on the falling edge
    always @(negedge clk) begin
        while (exp_q.size() != 0) begin
            mon_sel = sel_q.pop_front();
            mon_exp = exp_q.pop_front();
            mon_act = probe(mon_sel);
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL %s actual=%08h expected=%08h", probe_name(mon_sel), mon_act, mon_exp);
            end
        end
    end

    // Driver tasks
    task automatic expect_val(input int sel, input logic [31:0] v);
        sel_q.push_back(sel);
        exp_q.push_back(v);
    endtask

    task automatic enter_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            dut.instr_mem.mem[i] = NOP;
            dut.data_mem.mem[i]  = 32'h0;
        end
    endtask

    task automatic put(input int idx, input logic [31:0] w);
        dut.instr_mem.mem[idx] = w;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        expect_val(SEL_PC, 32'h0);
        expect_val(1, 32'h0);
        expect_val(31, 32'h0);

        // addi x1,5; addi x2,10; add x3,x1,x2
        enter_reset();
        put(0, 32'h0050_0093); put(1, 32'h00A0_0113); put(2, 32'h0020_81B3);
        release_reset();
        run(3);
        expect_val(3, 32'd15);
        expect_val(SEL_PC, 32'd12);

        // Mid-program reset clears pc and regs before the next edge
        enter_reset();
        put(0, 32'h0050_0093); put(1, 32'h00A0_0113); put(2, 32'h0020_81B3);
        release_reset();
        run(1);
        expect_val(1, 32'd5);
        expect_val(SEL_PC, 32'd4);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        expect_val(SEL_PC, 32'h0);
        expect_val(1, 32'h0);
        expect_val(2, 32'h0);
        release_reset();
        run(3);
        expect_val(3, 32'd15);
        expect_val(SEL_PC, 32'd12);

        // sw / lb / lbu
        enter_reset();
        put(0, 32'hFFF0_0093); put(1, 32'h0010_2423); put(2, 32'h0080_0103); put(3, 32'h0080_4183);
        release_reset();
        run(4);
        expect_val(SEL_MEM + 2, 32'hFFFF_FFFF);
        expect_val(2, 32'hFFFF_FFFF);
        expect_val(3, 32'h0000_00FF);

        // taken bne skips one instruction
        enter_reset();
        put(0, 32'h0010_0093); put(1, 32'h0000_9463); put(2, 32'h0070_0113); put(3, 32'h0090_0193);
        release_reset();
        run(3);
        expect_val(2, 32'h0);
        expect_val(3, 32'd9);
        expect_val(SEL_PC, 32'd16);

        // jal x1,+8 then jalr x0,0(x1)
        enter_reset();
        put(0, 32'h0080_00EF); put(2, 32'h0000_8067);
        release_reset();
        run(1);
        expect_val(SEL_PC, 32'd8);
        run(1);
        expect_val(1, 32'd4);
        expect_val(SEL_PC, 32'd4);

        // x0 write discarded; lui
        enter_reset();
        put(0, 32'h0050_0013); put(1, 32'h1234_5237);
        release_reset();
        run(2);
        expect_val(0, 32'h0);
        expect_val(4, 32'h1234_5000);

        // srai / slt / sltu / sub / sh / lh / lhu
        enter_reset();
        put(0, 32'hFF80_0093); put(1, 32'h4010_D113); put(2, 32'h0000_A1B3); put(3, 32'h0010_3233);
        put(4, 32'h4010_02B3); put(5, 32'h0010_1323); put(6, 32'h0060_1303); put(7, 32'h0060_5383);
        release_reset();
        run(8);
        expect_val(1, 32'hFFFF_FFF8);
        expect_val(2, 32'hFFFF_FFFC);
        expect_val(3, 32'd1);
        expect_val(4, 32'd1);
        expect_val(5, 32'd8);
        expect_val(SEL_MEM + 1, 32'hFFF8_0000);
        expect_val(6, 32'hFFFF_FFF8);
        expect_val(7, 32'h0000_FFF8);

        // Final report: drain the scoreboard within a bounded wait
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
